mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM register outputs and drives a handshaked data-memory port.
- It performs byte-lane steering and load extension, stalls the front of the pipeline while a memory access is outstanding, and registers results into the MEM/WB boundary.
- It also inserts a write-back bubble during stall cycles.

Parameters:
- ADDR_W, 32, width of the memory address.
- DATA_W, 32, datapath width; fixed at 32 because lane logic assumes 4 bytes.

Ports:
- Clk  in  1  clock; all state on rising edge
- Rst_n  in  1  asynchronous active-low reset
- inALUResult  in  32  effective address, or ALU result passed through
- inData2  in  32  store data
- inRegDest  in  5  destination register
- inPCCounter  in  32  PC, passed through for link/writeback
- inHazardRegWrite  in  1  writeback enable
- inHazardMemRead  in  2  00 none, 01 word, 10 half, 11 byte
- inHazardMemWrite  in  2  same encoding as inHazardMemRead
- inHazardMemToRegMux  in  3  writeback select, passed through
- inLoadUnsigned  in  1  1 = zero-extend sub-word loads
- MemReq  out  1  request valid
- MemWe  out  1  1 = write
- MemAddr  out  32  word-aligned address {inALUResult[31:2],2'b00}
- MemWData  out  32  lane-replicated store data
- MemByteEn  out  4  byte enables, little-endian
- MemRData  in  32  read data, valid with MemAck
- MemAck  in  1  transfer complete this cycle
- Stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- outReadData  out  32  extended load data
- outALUResult  out  32  registered pass-through
- outRegDest  out  5  registered pass-through
- outPCCounter  out  32  registered pass-through
- outHazardRegWrite  out  1  registered writeback enable
- outHazardMemToRegMux  out  3  registered pass-through
- MisalignErr  out  1  registered one-cycle error pulse; driven only when MISALIGN_TRAP_EN is defined

Behaviour:
- Reset: asynchronous on Rst_n low.
  - All registered outputs go to 0 and the FSM goes to IDLE.
  - MemReq and Stall go to 0 immediately.
  - A transaction in flight is abandoned; any late MemAck is ignored.
- Memory op: op = (MemRead != 0) || (MemWrite != 0).
  - If both fields are non-zero, the write wins and the read is ignored.
- FSM states: IDLE and BUSY.
  - IDLE, no op: MemReq = 0, Stall = 0. All out* registers load their in* values on the next edge (1-cycle latency); outReadData loads 0.
  - IDLE, op present: MemReq = 1 combinationally.
    - MemAck in the same cycle: zero-wait transfer. Stall = 0; MEM/WB captures on that edge; stay in IDLE.
    - Otherwise: Stall = 1; go to BUSY.
  - BUSY: MemReq = 1 and Stall = 1 until MemAck. MemAddr, MemWe, MemWData and MemByteEn stay stable (the EX/MEM inputs are frozen by Stall).
  - BUSY with MemAck: Stall = 0; MEM/WB captures; go to IDLE.
- Bubble: on every edge where Stall = 1, outHazardRegWrite loads 0 and outRegDest loads 0. The other outputs hold their values.
- Store lanes:
  - Byte: MemWData = {4{d[7:0]}}, MemByteEn = 4'b0001 << a[1:0].
  - Half: MemWData = {2{d[15:0]}}, MemByteEn = a[1] ? 4'b1100 : 4'b0011.
  - Word: MemWData = d, MemByteEn = 4'b1111.
- Load lanes:
  - MemByteEn is 1111 for all reads.
  - Select byte a[1:0] or half a[1], then sign-extend, or zero-extend when inLoadUnsigned = 1.
  - Word loads pass through unchanged.
- MemRData is sampled only on an edge where MemAck = 1.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a half access with a[0] = 1, or a word access with a[1:0] != 0, is misaligned. For a misaligned access:
  - MemReq is suppressed and Stall = 0.
  - MEM/WB captures with outHazardRegWrite = 0.
  - MisalignErr pulses 1 for one cycle.
- Undefined: the low address bits the access size cannot use are ignored. Half accesses use a[1]; word accesses are forced aligned. MisalignErr is tied to 0.

Decomposition:
- Package mem_stage_pkg:
  - Size encodings: MEM_NONE, MEM_WORD, MEM_HALF, MEM_BYTE.
  - FSM state typedef: IDLE, BUSY.
  - Byte-enable constants.
- One sub-module, mem_lane_steer: purely combinational store replication, byte-enable generation and load extraction/extension. The FSM and MEM/WB registers stay in the top module.

Test Plan:
- Non-memory op: ALUResult = 0x1234, RegWrite = 1, RegDest = 5 -> outputs match one edge later; MemReq never asserted; Stall = 0.
- Word load, ack after 3 cycles: addr 0x100, MemRData = 0xDEADBEEF.
  - Stall high for 3 cycles, with outHazardRegWrite = 0 on those edges.
  - Then outReadData = 0xDEADBEEF, RegWrite = 1.
- Signed byte load, zero-wait ack: addr 0x103, MemRData = 0x80FF0000 -> outReadData = 0xFFFFFF80; with inLoadUnsigned = 1 -> 0x00000080; no stall.
- Half store: addr 0x202, data 0x0000ABCD -> MemWe = 1, MemByteEn = 1100, MemWData = 0xABCDABCD, MemAddr = 0x200.
- Reset mid-transaction: Rst_n low while in BUSY -> MemReq and Stall drop the same cycle; outputs 0; a MemAck after release has no effect.
- Misaligned word load at 0x101, with MISALIGN_TRAP_EN defined -> MisalignErr pulses 1 cycle, no MemReq, outHazardRegWrite = 0; without the macro -> MemAddr = 0x100 and a normal load.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS MEM stage: access-size encodings, FSM states,
// byte-enable constants and the natural-alignment test.
// No logic of its own; imported by mem_lane_steer and mem_stage_access.
package mem_stage_pkg;

    // Access size, as carried in the MemRead / MemWrite control fields.
    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_WORD = 2'b01,
        MEM_HALF = 2'b10,
        MEM_BYTE = 2'b11
    } mem_size_e;

    // Memory-port handshake state.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    // Little-endian byte enables.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    // True when the low address bits are not naturally aligned for the size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == MEM_HALF) && lo[0]) || ((size == MEM_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: store replication, byte enables, load extract/extend.
// Latency: purely combinational, no state.
// Backpressure: none; the caller owns all handshaking.
//
// Ports:
//   addr_lo_i        low two address bits (lane select)
//   size_i           access size (mem_size_e encoding)
//   is_write_i       1 = store lanes / enables, 0 = read enables (all lanes)
//   load_unsigned_i  1 = zero-extend sub-word loads
//   st_data_i        raw store data          -> st_data_o  lane-replicated data
//                                            -> byte_en_o  byte enables
//   ld_raw_i         raw 32-bit read data    -> ld_data_o  extracted/extended load
module mem_lane_steer
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        is_write_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] st_data_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Lane selection for sub-word loads; halves only look at bit 1 so a
    // misaligned half (when not trapped) lands on its containing half-word.
    always_comb begin
        ld_byte = ld_raw_i[7:0];
        case (addr_lo_i)
            2'd0:    ld_byte = ld_raw_i[7:0];
            2'd1:    ld_byte = ld_raw_i[15:8];
            2'd2:    ld_byte = ld_raw_i[23:16];
            default: ld_byte = ld_raw_i[31:24];
        endcase
        ld_half = addr_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    end

    always_comb begin
        st_data_o = st_data_i;
        byte_en_o = BE_ALL;
        ld_data_o = ld_raw_i;

        // Stores replicate the sub-word across all lanes so the memory only
        // has to honour the byte enables; reads always fetch the full word.
        if (is_write_i) begin
            case (size_i)
                MEM_BYTE: begin
                    st_data_o = {4{st_data_i[7:0]}};
                    byte_en_o = BE_BYTE0 << addr_lo_i;
                end
                MEM_HALF: begin
                    st_data_o = {2{st_data_i[15:0]}};
                    byte_en_o = addr_lo_i[1] ? BE_HI_HALF : BE_LO_HALF;
                end
                default: begin
                    st_data_o = st_data_i;
                    byte_en_o = BE_ALL;
                end
            endcase
        end

        case (size_i)
            MEM_BYTE: ld_data_o = load_unsigned_i ? {24'd0, ld_byte}
                                                  : {{24{ld_byte[7]}}, ld_byte};
            MEM_HALF: ld_data_o = load_unsigned_i ? {16'd0, ld_half}
                                                  : {{16{ld_half[15]}}, ld_half};
            default:  ld_data_o = ld_raw_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// MIPS MEM stage: drives the handshaked data-memory port and the MEM/WB register.
// Latency: 1 cycle to MEM/WB with no op or a zero-wait ack; otherwise until MemAck.
// Backpressure: Stall holds the front pipeline while a request waits for MemAck;
//               each stalled edge writes a bubble (RegWrite=0, RegDest=0) into MEM/WB.
//
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses are not
// issued; they complete at once with writeback disabled and a one-cycle
// MisalignErr pulse. Without it the unusable low address bits are ignored
// and MisalignErr is tied low.
//
// Ports:
//   Clk, Rst_n                      clock, asynchronous active-low reset
//   in*                             EX/MEM register outputs (frozen while Stall=1)
//   MemReq/MemWe/MemAddr/MemWData/MemByteEn   request to data memory
//   MemRData/MemAck                 response; read data valid with MemAck
//   Stall                           hold PC, IF/ID, ID/EX and EX/MEM
//   out*                            MEM/WB register outputs
//   MisalignErr                     registered misalignment pulse
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] inALUResult,
    input  logic [DATA_W-1:0] inData2,
    input  logic [4:0]        inRegDest,
    input  logic [31:0]       inPCCounter,
    input  logic              inHazardRegWrite,
    input  logic [1:0]        inHazardMemRead,
    input  logic [1:0]        inHazardMemWrite,
    input  logic [2:0]        inHazardMemToRegMux,
    input  logic              inLoadUnsigned,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic [3:0]        MemByteEn,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck,
    output logic              Stall,
    output logic [DATA_W-1:0] outReadData,
    output logic [DATA_W-1:0] outALUResult,
    output logic [4:0]        outRegDest,
    output logic [31:0]       outPCCounter,
    output logic              outHazardRegWrite,
    output logic [2:0]        outHazardMemToRegMux,
    output logic              MisalignErr
);

    // ------------------------------------------------------------------
    // Operation decode. A write wins over a simultaneous read.
    // ------------------------------------------------------------------
    logic       wr_op;
    logic       rd_op;
    logic       op;
    logic [1:0] size;
    logic       misalign;
    logic       access;

    assign wr_op = (inHazardMemWrite != MEM_NONE);
    assign rd_op = (inHazardMemRead != MEM_NONE) && !wr_op;
    assign op    = wr_op || rd_op;
    assign size  = wr_op ? inHazardMemWrite : inHazardMemRead;

`ifdef MISALIGN_TRAP_EN
    assign misalign = op && is_misaligned(size, inALUResult[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // An access that actually goes out on the memory port.
    assign access = op && !misalign;

    // ------------------------------------------------------------------
    // Lane steering
    // ------------------------------------------------------------------
    logic [31:0] st_data;
    logic [3:0]  byte_en;
    logic [31:0] ld_data;

    mem_lane_steer u_lane_steer (
        .addr_lo_i       (inALUResult[1:0]),
        .size_i          (size),
        .is_write_i      (wr_op),
        .load_unsigned_i (inLoadUnsigned),
        .st_data_i       (inData2),
        .ld_raw_i        (MemRData),
        .st_data_o       (st_data),
        .byte_en_o       (byte_en),
        .ld_data_o       (ld_data)
    );

    assign MemWe     = wr_op;
    assign MemAddr   = {inALUResult[ADDR_W-1:2], 2'b00};
    assign MemWData  = st_data;
    assign MemByteEn = op ? byte_en : BE_NONE;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    mem_state_e state_q;
    mem_state_e state_d;
    logic       mem_req;
    logic       stall;
    logic       capture;   // MEM/WB loads the EX/MEM values this edge
    logic       bubble;    // MEM/WB writes a bubble this edge

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        stall   = 1'b0;
        capture = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!access) begin
                    capture = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (MemAck) begin
                        capture = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                if (MemAck) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request and stall must collapse while reset is held, even though the
    // EX/MEM inputs may still present an operation.
    assign MemReq = mem_req && Rst_n;
    assign Stall  = stall && Rst_n;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] read_data_d;
    logic [DATA_W-1:0] alu_result_q;
    logic [4:0]        reg_dest_q;
    logic [31:0]       pc_counter_q;
    logic              reg_write_q;
    logic [2:0]        mem_to_reg_q;

    // Read data is only meaningful on the ack edge of a real load.
    assign read_data_d = (rd_op && access && MemAck) ? ld_data : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            reg_dest_q   <= '0;
            pc_counter_q <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= '0;
        end else if (capture) begin
            read_data_q  <= read_data_d;
            alu_result_q <= inALUResult;
            reg_dest_q   <= inRegDest;
            pc_counter_q <= inPCCounter;
            reg_write_q  <= inHazardRegWrite && !misalign;
            mem_to_reg_q <= inHazardMemToRegMux;
        end else if (bubble) begin
            reg_dest_q  <= '0;
            reg_write_q <= 1'b0;
        end
    end

    assign outReadData          = read_data_q;
    assign outALUResult         = alu_result_q;
    assign outRegDest           = reg_dest_q;
    assign outPCCounter         = pc_counter_q;
    assign outHazardRegWrite    = reg_write_q;
    assign outHazardMemToRegMux = mem_to_reg_q;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    // Misaligned accesses always retire in IDLE on the capture edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= capture && misalign;
        end
    end

    assign MisalignErr = misalign_q;
`else
    assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: vector table of single-transfer
// cases plus hand-written wait-state, reset and misalignment sequences.
module tb_mem_stage_access;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] inALUResult;
    logic [31:0] inData2;
    logic [4:0]  inRegDest;
    logic [31:0] inPCCounter;
    logic        inHazardRegWrite;
    logic [1:0]  inHazardMemRead;
    logic [1:0]  inHazardMemWrite;
    logic [2:0]  inHazardMemToRegMux;
    logic        inLoadUnsigned;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemByteEn;
    logic [31:0] MemRData;
    logic        MemAck;
    logic        Stall;
    logic [31:0] outReadData;
    logic [31:0] outALUResult;
    logic [4:0]  outRegDest;
    logic [31:0] outPCCounter;
    logic        outHazardRegWrite;
    logic [2:0]  outHazardMemToRegMux;
    logic        MisalignErr;

    int checks   = 0;
    int failures = 0;

    mem_stage_access dut (
        .Clk                  (Clk),
        .Rst_n                (Rst_n),
        .inALUResult          (inALUResult),
        .inData2              (inData2),
        .inRegDest            (inRegDest),
        .inPCCounter          (inPCCounter),
        .inHazardRegWrite     (inHazardRegWrite),
        .inHazardMemRead      (inHazardMemRead),
        .inHazardMemWrite     (inHazardMemWrite),
        .inHazardMemToRegMux  (inHazardMemToRegMux),
        .inLoadUnsigned       (inLoadUnsigned),
        .MemReq               (MemReq),
        .MemWe                (MemWe),
        .MemAddr              (MemAddr),
        .MemWData             (MemWData),
        .MemByteEn            (MemByteEn),
        .MemRData             (MemRData),
        .MemAck               (MemAck),
        .Stall                (Stall),
        .outReadData          (outReadData),
        .outALUResult         (outALUResult),
        .outRegDest           (outRegDest),
        .outPCCounter         (outPCCounter),
        .outHazardRegWrite    (outHazardRegWrite),
        .outHazardMemToRegMux (outHazardMemToRegMux),
        .MisalignErr          (MisalignErr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [31:0] alu;
        logic [31:0] d2;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  mr;
        logic [1:0]  mw;
        logic [2:0]  m2r;
        logic        uns;
        logic        ack;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_rdat;
        logic        e_rw;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(
        input logic [31:0] alu, input logic [31:0] d2, input logic [31:0] pc,
        input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
        input logic [1:0] mr, input logic [1:0] mw, input logic [2:0] m2r,
        input logic uns, input logic ack,
        input logic e_req, input logic e_we, input logic [31:0] e_addr,
        input logic [31:0] e_wdata, input logic [3:0] e_be,
        input logic [31:0] e_rdat, input logic e_rw);
        vec_t v;
        v.alu = alu; v.d2 = d2; v.pc = pc; v.rdata = rdata; v.rd = rd; v.rw = rw;
        v.mr = mr; v.mw = mw; v.m2r = m2r; v.uns = uns; v.ack = ack;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_be = e_be; v.e_rdat = e_rdat; v.e_rw = e_rw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic drive(
        input logic [31:0] alu, input logic [31:0] d2, input logic [31:0] pc,
        input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
        input logic [1:0] mr, input logic [1:0] mw, input logic [2:0] m2r,
        input logic uns, input logic ack);
        inALUResult         = alu;
        inData2             = d2;
        inPCCounter         = pc;
        MemRData            = rdata;
        inRegDest           = rd;
        inHazardRegWrite    = rw;
        inHazardMemRead     = mr;
        inHazardMemWrite    = mw;
        inHazardMemToRegMux = m2r;
        inLoadUnsigned      = uns;
        MemAck              = ack;
    endtask

    task automatic drive_idle();
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, outReadData, 32'h0);
        chk({tag, "_alu"}, outALUResult, 32'h0);
        chk({tag, "_rd"}, {27'd0, outRegDest}, 32'h0);
        chk({tag, "_pc"}, outPCCounter, 32'h0);
        chk1({tag, "_rw"}, outHazardRegWrite, 1'b0);
        chk({tag, "_m2r"}, {29'd0, outHazardMemToRegMux}, 32'h0);
        chk1({tag, "_misalign"}, MisalignErr, 1'b0);
    endtask

    initial begin
        //           alu          d2           pc           rdata        rd  rw mr  mw  m2r uns ack | req we addr         wdata        be      rdat         rw
        vecs[0]  = mk(32'h1234,   32'h0,       32'h400,     32'h0,       5,  1, 0,  0,  1,  0,  0,   0,  0, 32'h1234,   32'h0,       4'h0,   32'h0,       1);
        vecs[1]  = mk(32'h103,    32'h0,       32'h404,     32'h80FF0000,7,  1, 3,  0,  2,  0,  1,   1,  0, 32'h100,    32'h0,       4'hF,   32'hFFFFFF80,1);
        vecs[2]  = mk(32'h103,    32'h0,       32'h408,     32'h80FF0000,7,  1, 3,  0,  2,  1,  1,   1,  0, 32'h100,    32'h0,       4'hF,   32'h00000080,1);
        vecs[3]  = mk(32'h202,    32'h0000ABCD,32'h40C,     32'h0,       0,  0, 0,  2,  0,  0,  1,   1,  1, 32'h200,    32'hABCDABCD,4'hC,   32'h0,       0);
        vecs[4]  = mk(32'h301,    32'h12345678,32'h410,     32'h0,       0,  0, 0,  3,  0,  0,  1,   1,  1, 32'h300,    32'h78787878,4'h2,   32'h0,       0);
        vecs[5]  = mk(32'h102,    32'h0,       32'h414,     32'h80017FFF,8,  1, 2,  0,  1,  0,  1,   1,  0, 32'h100,    32'h0,       4'hF,   32'hFFFF8001,1);
        vecs[6]  = mk(32'h100,    32'h0,       32'h418,     32'h1234F00D,10, 1, 2,  0,  1,  1,  1,   1,  0, 32'h100,    32'h0,       4'hF,   32'h0000F00D,1);
        vecs[7]  = mk(32'h400,    32'hCAFEBABE,32'h41C,     32'h0,       0,  0, 0,  1,  0,  0,  1,   1,  1, 32'h400,    32'hCAFEBABE,4'hF,   32'h0,       0);
        vecs[8]  = mk(32'h503,    32'h000000A5,32'h420,     32'hFFFFFFFF,0,  0, 1,  3,  0,  0,  1,   1,  1, 32'h500,    32'hA5A5A5A5,4'h8,   32'h0,       0);
        vecs[9]  = mk(32'h104,    32'h0,       32'h424,     32'h11223344,31, 1, 1,  0,  4,  0,  1,   1,  0, 32'h104,    32'h0,       4'hF,   32'h11223344,1);
        vecs[10] = mk(32'h102,    32'h0,       32'h428,     32'h11AB2233,12, 1, 3,  0,  1,  0,  1,   1,  0, 32'h100,    32'h0,       4'hF,   32'hFFFFFFAB,1);

        Rst_n = 1'b0;
        drive_idle();
        #2;
        chk1("reset_req", MemReq, 1'b0);
        chk1("reset_stall", Stall, 1'b0);
        chk_all_zero("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        // Single-transfer vectors: no-op or zero-wait ack from IDLE.
        for (int i = 0; i < 11; i++) begin
            @(negedge Clk);
            drive(vecs[i].alu, vecs[i].d2, vecs[i].pc, vecs[i].rdata, vecs[i].rd,
                  vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].m2r, vecs[i].uns, vecs[i].ack);
            #2;
            chk1($sformatf("vec%0d_req", i), MemReq, vecs[i].e_req);
            chk1($sformatf("vec%0d_stall", i), Stall, 1'b0);
            if (vecs[i].e_req) begin
                chk1($sformatf("vec%0d_we", i), MemWe, vecs[i].e_we);
                chk($sformatf("vec%0d_addr", i), MemAddr, vecs[i].e_addr);
                chk($sformatf("vec%0d_be", i), {28'd0, MemByteEn}, {28'd0, vecs[i].e_be});
            end
            if (vecs[i].e_we) begin
                chk($sformatf("vec%0d_wdata", i), MemWData, vecs[i].e_wdata);
            end
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d_rdata", i), outReadData, vecs[i].e_rdat);
            chk($sformatf("vec%0d_alu", i), outALUResult, vecs[i].alu);
            chk($sformatf("vec%0d_rd", i), {27'd0, outRegDest}, {27'd0, vecs[i].rd});
            chk($sformatf("vec%0d_pc", i), outPCCounter, vecs[i].pc);
            chk1($sformatf("vec%0d_rw", i), outHazardRegWrite, vecs[i].e_rw);
            chk($sformatf("vec%0d_m2r", i), {29'd0, outHazardMemToRegMux}, {29'd0, vecs[i].m2r});
        end

        // Non-memory op with distinct values so holds and resets are visible.
        @(negedge Clk);
        drive(32'h777, 32'h0, 32'h4FC, 32'h0, 5'd6, 1'b1, 2'b00, 2'b00, 3'd2, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        chk("noop_rdata", outReadData, 32'h0);
        chk("noop_alu", outALUResult, 32'h777);

        // Word load with three wait cycles; bus garbage must not be sampled.
        @(negedge Clk);
        drive(32'h100, 32'h0, 32'h500, 32'h55555555, 5'd9, 1'b1, 2'b01, 2'b00, 3'd1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk1($sformatf("wait%0d_stall", c), Stall, 1'b1);
            chk1($sformatf("wait%0d_req", c), MemReq, 1'b1);
            chk($sformatf("wait%0d_addr", c), MemAddr, 32'h100);
            @(posedge Clk);
            #1;
            chk1($sformatf("wait%0d_rw", c), outHazardRegWrite, 1'b0);
            chk($sformatf("wait%0d_rd", c), {27'd0, outRegDest}, 32'h0);
            chk($sformatf("wait%0d_rdata", c), outReadData, 32'h0);
            chk($sformatf("wait%0d_alu_hold", c), outALUResult, 32'h777);
            @(negedge Clk);
        end
        MemAck   = 1'b1;
        MemRData = 32'hDEADBEEF;
        #2;
        chk1("ack_stall", Stall, 1'b0);
        chk1("ack_req", MemReq, 1'b1);
        @(posedge Clk);
        #1;
        chk("ack_rdata", outReadData, 32'hDEADBEEF);
        chk1("ack_rw", outHazardRegWrite, 1'b1);
        chk("ack_rd", {27'd0, outRegDest}, 32'd9);
        chk("ack_alu", outALUResult, 32'h100);
        chk("ack_pc", outPCCounter, 32'h500);
        @(negedge Clk);
        drive_idle();
        #2;
        chk1("after_ack_req", MemReq, 1'b0);
        chk1("after_ack_stall", Stall, 1'b0);

        // Reset while BUSY: request and stall drop at once, late ack ignored.
        @(negedge Clk);
        drive(32'h200, 32'h0, 32'h600, 32'h0, 5'd4, 1'b1, 2'b01, 2'b00, 3'd1, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        chk1("busy_stall", Stall, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk1("rst_busy_req", MemReq, 1'b0);
        chk1("rst_busy_stall", Stall, 1'b0);
        chk_all_zero("rst_busy");
        @(negedge Clk);
        drive_idle();
        Rst_n = 1'b1;
        @(negedge Clk);
        MemAck   = 1'b1;
        MemRData = 32'hFFFFFFFF;
        #2;
        chk1("late_ack_req", MemReq, 1'b0);
        chk1("late_ack_stall", Stall, 1'b0);
        @(posedge Clk);
        #1;
        chk("late_ack_rdata", outReadData, 32'h0);
        chk1("late_ack_rw", outHazardRegWrite, 1'b0);

        // Misaligned word load at 0x101.
        @(negedge Clk);
        drive(32'h101, 32'h0, 32'h700, 32'h99999999, 5'd3, 1'b1, 2'b01, 2'b00, 3'd1, 1'b0, 1'b1);
        #2;
        chk1("mis_stall", Stall, 1'b0);
`ifdef MISALIGN_TRAP_EN
        chk1("mis_req", MemReq, 1'b0);
        @(posedge Clk);
        #1;
        chk1("mis_err", MisalignErr, 1'b1);
        chk1("mis_rw", outHazardRegWrite, 1'b0);
        chk("mis_rd", {27'd0, outRegDest}, 32'd3);
        chk("mis_rdata", outReadData, 32'h0);
`else
        chk1("mis_req", MemReq, 1'b1);
        chk("mis_addr", MemAddr, 32'h100);
        @(posedge Clk);
        #1;
        chk1("mis_err", MisalignErr, 1'b0);
        chk1("mis_rw", outHazardRegWrite, 1'b1);
        chk("mis_rdata", outReadData, 32'h99999999);
`endif
        @(negedge Clk);
        drive_idle();
        @(posedge Clk);
        #1;
        chk1("mis_err_clear", MisalignErr, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
